// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters, with retry and timeout abort.
// Latency: grant to TxNewData is 1 cycle; Ack/Err pulse the cycle after the completing or aborting event.
// Backpressure: Req is held until Ack/Err; a grant is only made from IDLE, so a new word waits out RELEASE.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int size      = 32,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic                     CLK_Baudin,
    input  logic                     RstArb_n,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*size-1:0]     ReqData,
    input  logic                     DoneTx,
    input  logic                     Flag_in,
    output logic [size-1:0]          TxData,
    output logic                     TxNewData,
    output logic                     TxRst,
    output logic [NREQ-1:0]          Ack,
    output logic [NREQ-1:0]          Err,
    output logic [$clog2(NREQ)-1:0]  GrantId,
    output logic                     Busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int RW  = $clog2(MAX_RETRY + 2);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] RELEASE   = 2'd3;

    logic [1:0]     state;
    logic [RW-1:0]  retry_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           done_q;
    logic           flag_q;
    logic           done_edge;
    logic           flag_edge;
    logic           retry_abort;
    logic           tmo_abort;
    logic           rr_found;
    logic [IDW-1:0] rr_idx;
    logic [IDW-1:0] cand;

    assign done_edge   = DoneTx & ~done_q;
    assign flag_edge   = Flag_in & ~flag_q;
    assign retry_abort = flag_edge && (int'(retry_cnt) + 1 > MAX_RETRY);
    assign tmo_abort   = (int'(tmo_cnt) + 1 >= TIMEOUT);

    assign TxNewData = (state == LOAD);
    assign Busy      = (state != IDLE);

    // Search starts one past the last grant so a held request cannot starve the rest.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(GrantId) + i + 1) % NREQ);
            if (!rr_found && Req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_ff @(posedge CLK_Baudin) begin
        if (!RstArb_n) begin
            state     <= IDLE;
            TxData    <= '0;
            TxRst     <= 1'b0;
            Ack       <= '0;
            Err       <= '0;
            GrantId   <= IDW'(NREQ - 1);
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            done_q    <= 1'b1;
            flag_q    <= 1'b0;
        end else begin
            // Edge history tracks every state so a DoneTx level left over from the last word is not a new edge.
            done_q <= DoneTx;
            flag_q <= Flag_in;
            Ack    <= '0;
            Err    <= '0;
            TxRst  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        GrantId   <= rr_idx;
                        TxData    <= ReqData[rr_idx*size +: size];
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: state <= WAIT_DONE;
                WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (flag_edge) retry_cnt <= retry_cnt + RW'(1);
                    if (done_edge) begin
                        Ack[GrantId] <= 1'b1;
                        state        <= RELEASE;
                    end else if (retry_abort || tmo_abort) begin
                        Err[GrantId] <= 1'b1;
                        TxRst        <= 1'b1;
                        state        <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single grant, round-robin, retry abort, done-vs-abort priority,
// timeout abort and mid-transfer reset, with pulse monitors for Ack/Err exclusivity.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [127:0] req_data;
    logic        done_tx;
    logic        flag_in;
    logic [31:0] tx_data;
    logic        tx_new_data;
    logic        tx_rst;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int nd_cnt = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    int excl_viol = 0;

    logic [31:0] words [4];
    int          rr_seq [5] = '{0, 1, 2, 3, 0};

    uart_tx_arbiter dut (
        .CLK_Baudin (clk),
        .RstArb_n   (rst_n),
        .Req        (req),
        .ReqData    (req_data),
        .DoneTx     (done_tx),
        .Flag_in    (flag_in),
        .TxData     (tx_data),
        .TxNewData  (tx_new_data),
        .TxRst      (tx_rst),
        .Ack        (ack),
        .Err        (err),
        .GrantId    (grant_id),
        .Busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_new_data === 1'b1) nd_cnt++;
        if (ack !== 4'bx) ack_cnt += $countones(ack);
        if (err !== 4'bx) err_cnt += $countones(err);
        if ((|ack === 1'b1 && |err === 1'b1) || $onehot0(ack) === 1'b0 || $onehot0(err) === 1'b0)
            excl_viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE with the requester's Req set: grant, wait, complete, return to IDLE.
    task automatic serve(input int id, input int delay);
        tick();
        chk("load_nd", tx_new_data, 1);
        chk("load_gid", grant_id, id);
        chk("load_data", tx_data, words[id]);
        repeat (delay) tick();
        chk("wait_nd", tx_new_data, 0);
        done_tx = 1'b1;
        tick();
        chk("ack", ack, 4'b0001 << id);
        chk("ack_noerr", err, 0);
        chk("ack_data_stable", tx_data, words[id]);
        done_tx = 1'b0;
        tick();
        chk("rel_ack_clear", ack, 0);
    endtask

    initial begin
        words[0] = 32'hA5A5_0001;
        words[1] = 32'h1111_2222;
        words[2] = 32'h3333_4444;
        words[3] = 32'hDEAD_BEEF;
        req_data = {words[3], words[2], words[1], words[0]};
        rst_n = 1'b0; req = '0; done_tx = 1'b0; flag_in = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_nd", tx_new_data, 0);
        chk("rst_txrst", tx_rst, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_gid", grant_id, 3);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Single requester, DoneTx rising 40 cycles after the load strobe.
        req = 4'b0001;
        serve(0, 39);
        req = 4'b0000;
        chk("single_busy_low", busy, 0);
        tick();
        chk("single_idle", busy, 0);
        chk("single_nd_once", nd_cnt, 1);

        // Round-robin from reset with all requesters held.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 4'b1111;
        foreach (rr_seq[k]) serve(rr_seq[k], 3);
        req = 4'b0000;
        tick();
        chk("rr_acks", ack_cnt, 6);

        // Four retransmit requests exhaust MAX_RETRY=3.
        req = 4'b0100;
        tick();
        chk("retry_gid", grant_id, 2);
        tick();
        for (int k = 1; k <= 4; k++) begin
            flag_in = 1'b1;
            tick();
            chk("retry_err", err, (k == 4) ? 4'b0100 : 4'b0000);
            chk("retry_txrst", tx_rst, (k == 4) ? 1 : 0);
            chk("retry_noack", ack, 0);
            flag_in = 1'b0;
            if (k < 4) tick();
        end
        req = 4'b0000;
        tick();
        chk("retry_rel_txrst", tx_rst, 0);
        tick();
        chk("retry_idle", busy, 0);

        // Aborting retry edge coincides with DoneTx rising: completion wins.
        req = 4'b1000;
        tick();
        chk("simul_gid", grant_id, 3);
        tick();
        for (int k = 1; k <= 3; k++) begin
            flag_in = 1'b1; tick();
            flag_in = 1'b0; tick();
        end
        chk("simul_pre_err", err, 0);
        flag_in = 1'b1; done_tx = 1'b1;
        tick();
        chk("simul_ack", ack, 4'b1000);
        chk("simul_noerr", err, 0);
        chk("simul_notxrst", tx_rst, 0);
        flag_in = 1'b0; done_tx = 1'b0; req = 4'b0000;
        tick(); tick();

        // Timeout: DoneTx never rises.
        req = 4'b0001;
        tick();
        chk("tmo_gid", grant_id, 0);
        tick();
        repeat (1022) tick();
        chk("tmo_early", err, 0);
        chk("tmo_busy", busy, 1);
        tick();
        chk("tmo_err", err, 4'b0001);
        chk("tmo_txrst", tx_rst, 1);
        chk("tmo_noack", ack, 0);
        req = 4'b0000;
        tick(); tick();
        chk("tmo_idle", busy, 0);

        // Reset in the middle of WAIT_DONE abandons the word silently.
        req = 4'b0010;
        tick();
        chk("rstmid_gid", grant_id, 1);
        tick();
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ack", ack, 0);
        chk("rstmid_err", err, 0);
        chk("rstmid_txrst", tx_rst, 0);
        rst_n = 1'b1; req = 4'b0011;
        tick();
        chk("rstmid_next_gid", grant_id, 0);
        chk("rstmid_next_nd", tx_new_data, 1);
        req = 4'b0000; rst_n = 1'b0;
        tick(); tick();

        chk("total_nd", nd_cnt, 11);
        chk("total_ack", ack_cnt, 7);
        chk("total_err", err_cnt, 2);
        chk("ack_err_excl", excl_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
